// File: rtl/dac_spi_master.sv
// -----------------------------------------------------------------------------
// dac_spi_master
//
// Bit-serial SPI master (mode 0) for the AD9783 configuration port. A complete
// frame (R/W, length, address, data) is accepted in one cycle. The block then
// shifts it out MSB first on SDO while capturing SDI into a parallel word. That
// word is published on data_out together with ready_out at the end of the
// deselect gap.
//
// Every non-idle state lasts D = max(SPI_CLK_DIV, 1) clk_in cycles.
//
// Ports:
//   clk_in       system clock (100 MHz)
//   rst_in       asynchronous, active-high reset
//   trigger_in   start request, sampled only while idle
//   data_in      frame to transmit, MSB first, latched on the accept edge
//   data_out     word captured from SDI, updated when a frame completes
//   ready_out    high while idle and able to accept a frame
//   spi_scs_out  chip select, active-low
//   spi_sck_out  serial clock, idles low
//   spi_sdo_out  serial data to the DAC
//   spi_sdi_in   serial data from the DAC
// -----------------------------------------------------------------------------
module dac_spi_master #(
   parameter int unsigned TRANSFER_SIZE = 16,
   parameter logic [7:0]  SPI_CLK_DIV   = 8'h05
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     trigger_in,
   input  logic [TRANSFER_SIZE-1:0] data_in,
   output logic [TRANSFER_SIZE-1:0] data_out,
   output logic                     ready_out,
   output logic                     spi_scs_out,
   output logic                     spi_sck_out,
   output logic                     spi_sdo_out,
   input  logic                     spi_sdi_in
);

   localparam int unsigned N = TRANSFER_SIZE;
   // A divider setting of 0 behaves like 1, so the terminal count is 0 for both.
   localparam logic [7:0]  DIV_LAST = (SPI_CLK_DIV == 8'd0) ? 8'd0 : SPI_CLK_DIV - 8'd1;
   localparam logic [5:0]  N_BITS   = 6'(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_HIGH,
      S_LOW,
      S_GAP
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     div_q,   div_d;
   logic [5:0]     bit_q,   bit_d;
   logic [N-1:0]   tx_q,    tx_d;
   logic [N-1:0]   rx_q,    rx_d;
   logic [N-1:0]   dout_q,  dout_d;
   logic           scs_q,   scs_d;
   logic           sck_q,   sck_d;
   logic           sdo_q,   sdo_d;
   logic           ready_q, ready_d;
   logic           tick;

   // The current state has lasted D cycles.
   assign tick = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that left
      // one unassigned would make the synthesis tool infer a latch.
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      scs_d   = scs_q;
      sck_d   = sck_q;
      sdo_d   = sdo_q;
      ready_d = ready_q;

      if (state_q != S_IDLE) begin
         div_d = tick ? 8'd0 : div_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (trigger_in) begin
               state_d = S_LEAD;
               div_d   = 8'd0;
               bit_d   = 6'd0;
               tx_d    = data_in;
               rx_d    = '0;
               scs_d   = 1'b0;
               sdo_d   = data_in[N-1];
               ready_d = 1'b0;
            end
         end

         S_LEAD: begin
            if (tick) begin
               state_d = S_HIGH;
               sck_d   = 1'b1;
               rx_d    = {rx_q[N-2:0], spi_sdi_in};
            end
         end

         S_HIGH: begin
            if (tick) begin
               state_d = S_LOW;
               sck_d   = 1'b0;
               bit_d   = bit_q + 6'd1;
               // After the last bit, SDO holds until the deselect edge.
               if (bit_d != N_BITS) begin
                  tx_d  = tx_q << 1;
                  sdo_d = tx_q[N-2];
               end
            end
         end

         S_LOW: begin
            if (tick) begin
               if (bit_q == N_BITS) begin
                  state_d = S_GAP;
                  scs_d   = 1'b1;
                  sdo_d   = 1'b0;
               end else begin
                  state_d = S_HIGH;
                  sck_d   = 1'b1;
                  rx_d    = {rx_q[N-2:0], spi_sdi_in};
               end
            end
         end

         S_GAP: begin
            if (tick) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               dout_d  = rx_q;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         // NOTE: the shift registers are ordinary flops, not a memory, so they
         // are reset with everything else; an aborted frame leaves no residue.
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         bit_q   <= 6'd0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         scs_q   <= 1'b1;
         sck_q   <= 1'b0;
         sdo_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // pre-edge values regardless of statement order.
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         scs_q   <= scs_d;
         sck_q   <= sck_d;
         sdo_q   <= sdo_d;
         ready_q <= ready_d;
      end
   end

   assign data_out    = dout_q;
   assign ready_out   = ready_q;
   assign spi_scs_out = scs_q;
   assign spi_sck_out = sck_q;
   assign spi_sdo_out = sdo_q;

endmodule

// File: tb/tb_dac_spi_master.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_master
//
// Self-checking bench for dac_spi_master. It drives a default instance (N=16,
// D=5) and a small instance (N=8, SPI_CLK_DIV=0). A slave model shifts a chosen
// word onto SDI on SCK falling edges, and a monitor records SDO at each SCK
// rise. Expected frames go into a scoreboard queue at the accept edge and are
// compared when ready_out returns high.
// -----------------------------------------------------------------------------
module tb_dac_spi_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trigger = 1'b0;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] data_out;
   logic        ready, scs, sck, sdo;
   logic        sdi = 1'b0;

   logic        trig8 = 1'b0;
   logic [7:0]  din8 = 8'h00;
   logic [7:0]  dout8;
   logic        rdy8, scs8, sck8, sdo8;
   logic        sdi8 = 1'b1;

   always #5 clk = ~clk;

   dac_spi_master u_dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .trigger_in  (trigger),
      .data_in     (data_in),
      .data_out    (data_out),
      .ready_out   (ready),
      .spi_scs_out (scs),
      .spi_sck_out (sck),
      .spi_sdo_out (sdo),
      .spi_sdi_in  (sdi)
   );

   dac_spi_master #(.TRANSFER_SIZE(8), .SPI_CLK_DIV(8'h00)) u_dut8 (
      .clk_in      (clk),
      .rst_in      (rst),
      .trigger_in  (trig8),
      .data_in     (din8),
      .data_out    (dout8),
      .ready_out   (rdy8),
      .spi_scs_out (scs8),
      .spi_sck_out (sck8),
      .spi_sdo_out (sdo8),
      .spi_sdi_in  (sdi8)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- slave model and bus monitors ----------------
   logic [15:0] slave_word = 16'h0000;
   int          slave_idx  = 0;

   always @(negedge scs) begin
      slave_idx = 0;
      sdi = slave_word[15];
   end

   always @(negedge sck) begin
      if (!scs) begin
         slave_idx++;
         sdi = (slave_idx < 16) ? slave_word[15-slave_idx] : 1'b0;
      end
   end

   logic [15:0] cap_sdo  = 16'h0000;
   int          rise_cnt = 0;
   int          sck_bad  = 0;

   always @(negedge scs) begin
      cap_sdo  = 16'h0000;
      rise_cnt = 0;
   end

   always @(posedge sck) begin
      cap_sdo = {cap_sdo[14:0], sdo};
      rise_cnt++;
   end

   // SCK must stay quiet while the slave is deselected (reset aborts excepted).
   always @(sck) begin
      if (scs === 1'b1 && rst === 1'b0) sck_bad++;
   end

   logic [7:0] cap8  = 8'h00;
   int         rise8 = 0;

   always @(negedge scs8) begin
      cap8  = 8'h00;
      rise8 = 0;
   end

   always @(posedge sck8) begin
      cap8 = {cap8[6:0], sdo8};
      rise8++;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [15:0] sdo;
      logic [15:0] dout;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] last_dout = 16'h0000;

   task automatic sb_compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, "_sdo_bits"}, 32'(cap_sdo), 32'(e.sdo));
         check({tag, "_data_out"}, 32'(data_out), 32'(e.dout));
         last_dout = e.dout;
      end
   endtask

   // One frame at the default parameters. busy_at >= 0 injects an ignored
   // trigger with data_in = FFFF sampled on edge E0+busy_at.
   task automatic run_frame(input string tag, input logic [15:0] din,
                            input logic [15:0] sdi_w, input logic [15:0] exp_sdo,
                            input logic [15:0] exp_dout, input int busy_at);
      int          scs_low;
      int          ready_at;
      logic [15:0] dout_pre;
      logic [15:0] prev;
      prev       = last_dout;
      dout_pre   = 16'hxxxx;
      slave_word = sdi_w;
      @(negedge clk);
      trigger = 1'b1;
      data_in = din;
      sb.push_back('{exp_sdo, exp_dout});
      @(posedge clk);
      #1;
      trigger  = 1'b0;
      data_in  = ~din;
      scs_low  = 0;
      ready_at = -1;
      for (int k = 0; k < 400 && ready_at < 0; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (scs === 1'b0) scs_low++;
         if (ready === 1'b1) ready_at = k;
         else dout_pre = data_out;
         if (busy_at >= 0 && k == busy_at - 1) begin
            trigger = 1'b1;
            data_in = 16'hFFFF;
         end else if (busy_at >= 0 && k == busy_at) begin
            trigger = 1'b0;
         end
      end
      check({tag, "_ready_at"}, 32'(ready_at), 32'd170);
      check({tag, "_scs_low"},  32'(scs_low),  32'd165);
      check({tag, "_dout_hold"}, 32'(dout_pre), 32'(prev));
      check({tag, "_sck_rises"}, 32'(rise_cnt), 32'd16);
      check({tag, "_sck_quiet"}, 32'(sck_bad),  32'd0);
      sb_compare(tag);
   endtask

   typedef struct {
      logic [15:0] din;
      logic [15:0] sdi_w;
      logic [15:0] exp_sdo;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t vecs[4];

   int acc_t[3];
   int n_acc, n_done, hi_run, min_hi, scs_low8, rdy8_at;
   bit prev_rdy, seen_low;

   initial begin
      vecs[0] = '{16'h0500, 16'h0000, 16'h0500, 16'h0000}; // SMP_DLY write
      vecs[1] = '{16'h8500, 16'h00A5, 16'h8500, 16'h00A5}; // readback
      vecs[2] = '{16'hA5C3, 16'hFFFF, 16'hA5C3, 16'hFFFF};
      vecs[3] = '{16'h0001, 16'h8001, 16'h0001, 16'h8001};

      #2 rst = 1'b1;
      #20;
      check("rst_scs",   32'(scs),      32'd1);
      check("rst_sck",   32'(sck),      32'd0);
      check("rst_sdo",   32'(sdo),      32'd0);
      check("rst_ready", 32'(ready),    32'd1);
      check("rst_dout",  32'(data_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].sdi_w,
                   vecs[i].exp_sdo, vecs[i].exp_dout, -1);
      end

      // Trigger during a frame is ignored; original bits go out.
      run_frame("busy", 16'h1357, 16'h2468, 16'h1357, 16'h2468, 50);
      repeat (3) @(posedge clk);
      #1;
      check("busy_no_requeue", 32'(ready), 32'd1);

      // Trigger held high for three frames.
      slave_word = 16'h3355;
      @(negedge clk);
      data_in  = 16'h0F0F;
      trigger  = 1'b1;
      n_acc    = 0;
      n_done   = 0;
      hi_run   = 0;
      min_hi   = 1000;
      prev_rdy = 1'b1;
      seen_low = 1'b0;
      for (int k = 0; k < 800 && n_done < 3; k++) begin
         @(posedge clk);
         #1;
         if (prev_rdy && ready === 1'b0) begin
            acc_t[n_acc] = k;
            n_acc++;
            sb.push_back('{16'h0F0F, 16'h3355});
            if (n_acc == 3) trigger = 1'b0;
         end
         if (!prev_rdy && ready === 1'b1) begin
            sb_compare($sformatf("cont%0d", n_done));
            n_done++;
         end
         if (scs === 1'b1) begin
            hi_run++;
         end else begin
            if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
            seen_low = 1'b1;
            hi_run   = 0;
         end
         prev_rdy = (ready === 1'b1);
      end
      trigger = 1'b0;
      check("cont_frames", 32'(n_done), 32'd3);
      check("cont_gap01",  32'(acc_t[1] - acc_t[0]), 32'd171);
      check("cont_gap12",  32'(acc_t[2] - acc_t[1]), 32'd171);
      check("cont_scs_hi_ge5", 32'(min_hi >= 5), 32'd1);

      // Reset at E0+80 aborts the frame immediately.
      slave_word = 16'hFFFF;
      @(negedge clk);
      trigger = 1'b1;
      data_in = 16'hFFFF;
      @(posedge clk);
      #1;
      trigger = 1'b0;
      check("abort_busy", 32'(ready), 32'd0);
      repeat (80) @(posedge clk);
      #1;
      check("abort_sdo_pre", 32'(sdo), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_scs",   32'(scs),      32'd1);
      check("abort_sck",   32'(sck),      32'd0);
      check("abort_sdo",   32'(sdo),      32'd0);
      check("abort_ready", 32'(ready),    32'd1);
      check("abort_dout",  32'(data_out), 32'd0);
      last_dout = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_frame("post_rst", 16'h8A5A, 16'h00C3, 16'h8A5A, 16'h00C3, -1);

      // Small instance: N=8, D=1.
      @(negedge clk);
      trig8 = 1'b1;
      din8  = 8'h3C;
      @(posedge clk);
      #1;
      trig8    = 1'b0;
      din8     = 8'hC3;
      scs_low8 = 0;
      rdy8_at  = -1;
      for (int k = 0; k < 100 && rdy8_at < 0; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (scs8 === 1'b0) scs_low8++;
         if (rdy8 === 1'b1) rdy8_at = k;
      end
      check("n8_ready_at", 32'(rdy8_at),  32'd18);
      check("n8_scs_low",  32'(scs_low8), 32'd17);
      check("n8_sdo_bits", 32'(cap8),     32'h3C);
      check("n8_rises",    32'(rise8),    32'd8);
      check("n8_dout",     32'(dout8),    32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
